apb_cmd_master: RTL and testbench
=================================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the paddr and cmd_addr width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data width; legal values are 8, 16 and 32.
REQ-003 The block SHALL have parameter CMD_DEPTH, default 4, meaning command FIFO entries; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum ACCESS cycles waiting for pready; 0 disables the timeout.
REQ-005 Ports SHALL be:
- clk  in  1  clock, rising-edge.
- rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_error  out  1  pslverr was seen, or the transfer timed out.
- rsp_timeout  out  1  the transfer ended by timeout.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes.
- pprot  out  3  APB protection.
- pready, pslverr  in  1 each  APB completion inputs.
- prdata  in  DATA_WIDTH  APB read data.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-006 A command SHALL be written into the FIFO when cmd_valid and cmd_ready are both 1 on a rising edge.
REQ-007 cmd_ready SHALL equal !full; when the FIFO is full, a push SHALL be refused even in the cycle a pop occurs.
REQ-008 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-009 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry, load it into the APB output registers and enter SETUP on the same edge.
- With the FIFO empty, there is one idle cycle between the command handshake and psel=1.
REQ-010 SETUP SHALL drive psel=1 and penable=0, and SHALL always go to ACCESS after one cycle.
REQ-011 ACCESS SHALL drive psel=1 and penable=1, and SHALL hold until pready=1 or the timeout fires.
REQ-012 paddr, pwrite, pwdata, pstrb and pprot SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-013 pstrb SHALL be all zeros on reads.
REQ-014 On an ACCESS edge with pready=1, the block SHALL register the response on that edge, so rsp_valid=1 in the following cycle:
- rsp_rdata = prdata for reads, 0 for writes.
- rsp_error = pslverr.
- rsp_timeout = 0.
REQ-015 A timeout counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with pready=0.
REQ-016 When TIMEOUT≠0 and the counter reaches TIMEOUT, the transfer SHALL end with rsp_valid=1, rsp_error=1, rsp_timeout=1 and rsp_rdata=0.
REQ-017 On completion (pready or timeout), the FSM SHALL pop the next entry and go directly to SETUP with psel held at 1 if the FIFO is non-empty, else go to IDLE with psel=0 and penable=0.
REQ-018 rsp_valid SHALL be a single-cycle pulse per completed transfer; there is no response backpressure.
REQ-019 When a FIFO push and pop occur on the same edge, the occupancy SHALL be unchanged and both operations SHALL take effect.
REQ-020 FIFO read and write pointers SHALL wrap modulo CMD_DEPTH, with one extra bit to distinguish full from empty.
REQ-021 When pready=1 and the timeout fires on the same edge, pready SHALL win: normal completion, rsp_timeout=0.

Reset
REQ-022 rstn=0 SHALL immediately, without waiting for clk, set:
- FSM to IDLE, FIFO empty, timeout counter = 0.
- psel=penable=pwrite=0; paddr, pwdata, pstrb and pprot all 0.
- rsp_valid=rsp_error=rsp_timeout=0, rsp_rdata=0, busy=0.
- cmd_ready=1.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer and discard all queued commands, with no response pulse.

Verification
REQ-024 Single write (addr 0x10, data 0xA5A5_0001, strb 0xF), pready tied 1 -> SETUP one cycle after the handshake, ACCESS next, then rsp_valid with rsp_error=0.
REQ-025 Four reads queued back-to-back (CMD_DEPTH=4), slave returning 0x11..0x44 with pready=1 -> psel stays high across all four, no IDLE gap, cmd_ready=0 while full, and responses arrive in order 0x11, 0x22, 0x33, 0x44.
REQ-026 Read with pready held 0 and TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_error=1, rsp_timeout=1, rsp_rdata=0.
REQ-027 Write with pslverr=1 and pready=1 after 3 wait cycles -> rsp_error=1, rsp_timeout=0, and the next queued command proceeds.
REQ-028 rstn pulsed low during ACCESS with 2 commands queued -> outputs go to reset values immediately, and no rsp_valid occurs afterwards.
REQ-029 Push offered while full in the same cycle as a pop -> the push is refused, occupancy drops by one, and the command is accepted on the next edge.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB command master: queues read/write commands in a small FIFO and plays
// them out as APB transfers, returning one response pulse per transfer.
module apb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic                    pready,
    input  logic                    pslverr,
    input  logic [DATA_WIDTH-1:0]   prdata,
    output logic                    busy
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(CMD_DEPTH);
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_W-1:0]     strb;
        logic [2:0]            prot;
    } cmd_t;

    state_e                state_q, state_d;
    cmd_t                  fifo_q [CMD_DEPTH];
    logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
    logic [TMO_W-1:0]      tmo_cnt_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_W-1:0]     pstrb_q;
    logic [2:0]            pprot_q;
    logic                  rsp_valid_q, rsp_error_q, rsp_timeout_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic full, empty, push, pop, done, tmo_fire;
    cmd_t head, cmd_in;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign cmd_ready = !full;
    assign push     = cmd_valid && !full;
    assign head     = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign cmd_in   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                        strb: cmd_strb, prot: cmd_prot};
    // pready has priority over the timeout on the same edge
    assign tmo_fire = (TIMEOUT != 0) && (state_q == ACCESS) && !pready &&
                      (tmo_cnt_q == TMO_LAST);
    assign done     = (state_q == ACCESS) && (pready || tmo_fire);
    assign pop      = !empty && ((state_q == IDLE) || done);
    assign busy     = !empty || (state_q != IDLE);

    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = empty ? IDLE : SETUP;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: APB phase signals decoded straight from the state
    always_comb begin
        psel    = (state_q != IDLE);
        penable = (state_q == ACCESS);
    end

    // Command storage; contents need no reset since pointers gate validity
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= cmd_in;
    end

    // FIFO pointers with an extra wrap bit for full/empty
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
        end
    end

    // APB address/data registers, loaded when a command is popped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
        end else if (pop) begin
            pwrite_q <= head.write;
            paddr_q  <= head.addr;
            pwdata_q <= head.wdata;
            pstrb_q  <= head.write ? head.strb : '0;
            pprot_q  <= head.prot;
        end
    end

    // Wait-state counter: cleared in SETUP, counts ACCESS cycles without pready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                              tmo_cnt_q <= '0;
        else if (state_q == SETUP)              tmo_cnt_q <= '0;
        else if (state_q == ACCESS && !pready)  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end

    // Response registers, captured on the completing ACCESS edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= done;
            if (done) begin
                rsp_rdata_q   <= (pready && !pwrite_q) ? prdata : '0;
                rsp_error_q   <= pready ? pslverr : 1'b1;
                rsp_timeout_q <= !pready;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small configurable APB slave.
module tb_apb_cmd_master;

    logic        clk, rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr, busy;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          acc_cnt, psel_cnt, psel_first;
    int          slave_wait = 0;
    bit          slave_err = 0;
    int          wcnt = 0;
    logic [33:0] rsp_q[$];
    int          rsp_cyc[$];

    apb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .pslverr(pslverr), .prdata(prdata), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Slave: pready after slave_wait wait states (negative = never); data = (addr>>2)*0x11
    initial begin
        pready = 0; pslverr = 0; prdata = '0;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                if (slave_wait >= 0 && wcnt >= slave_wait) begin
                    pready = 1; pslverr = slave_err && pwrite;
                end else begin
                    pready = 0; pslverr = 0;
                end
                wcnt++;
            end else begin
                pready = 0; pslverr = 0; wcnt = 0;
            end
            prdata = (paddr >> 2) * 32'h11;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (rsp_valid) begin
            rsp_q.push_back({rsp_timeout, rsp_error, rsp_rdata});
            rsp_cyc.push_back(cyc);
        end
        if (psel && penable) acc_cnt++;
        if (psel) begin
            psel_cnt++;
            if (psel_first < 0) psel_first = cyc;
        end
    endtask

    task automatic clear_stats();
        rsp_q.delete(); rsp_cyc.delete();
        acc_cnt = 0; psel_cnt = 0; psel_first = -1;
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        cmd_strb = 4'hF; cmd_prot = 3'b010;
        while (!cmd_ready && n < 200) begin step(); n++; end
        if (!cmd_ready) chk("push_wait", 32'(cmd_ready), 1);
        step();
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (rsp_q.size() < n && k < 300) begin step(); k++; end
        if (rsp_q.size() < n) chk("rsp_wait", 32'(rsp_q.size()), 32'(n));
    endtask

    initial begin
        logic [33:0] e;
        rstn = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0;
        clear_stats();
        #2 rstn = 0;
        #1;
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        step(); step();
        rstn = 1;
        step();

        // Single write, zero wait states
        clear_stats(); slave_wait = 0; slave_err = 0;
        push_cmd(1, 32'h10, 32'hA5A5_0001);
        chk("wr_idle_gap_psel", 32'(psel), 0);
        chk("wr_busy", 32'(busy), 1);
        step();
        chk("wr_setup_psel", 32'(psel), 1);
        chk("wr_setup_penable", 32'(penable), 0);
        chk("wr_paddr", paddr, 32'h10);
        chk("wr_pwdata", pwdata, 32'hA5A5_0001);
        chk("wr_pstrb", 32'(pstrb), 32'hF);
        chk("wr_pwrite", 32'(pwrite), 1);
        chk("wr_pprot", 32'(pprot), 2);
        step();
        chk("wr_access_penable", 32'(penable), 1);
        chk("wr_access_paddr", paddr, 32'h10);
        step();
        chk("wr_done_psel", 32'(psel), 0);
        chk("wr_rsp_valid", 32'(rsp_valid), 1);
        chk("wr_rsp_error", 32'(rsp_error), 0);
        chk("wr_rsp_timeout", 32'(rsp_timeout), 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        step();
        chk("wr_rsp_pulse", 32'(rsp_valid), 0);
        chk("wr_busy_end", 32'(busy), 0);

        // Four back-to-back reads, no IDLE gap
        clear_stats();
        push_cmd(0, 32'h4, 32'hFFFF_FFFF);
        push_cmd(0, 32'h8, 32'h0);
        chk("rd_pstrb_zero", 32'(pstrb), 0);
        chk("rd_paddr0", paddr, 32'h4);
        chk("rd_pwrite0", 32'(pwrite), 0);
        push_cmd(0, 32'hC, 32'h0);
        push_cmd(0, 32'h10, 32'h0);
        wait_rsp(4);
        chk("rd_psel_cycles", 32'(psel_cnt), 8);
        chk("rd_span", 32'(rsp_cyc[3] - psel_first), 8);
        chk("rd_data0", rsp_q[0][31:0], 32'h11);
        chk("rd_data1", rsp_q[1][31:0], 32'h22);
        chk("rd_data2", rsp_q[2][31:0], 32'h33);
        chk("rd_data3", rsp_q[3][31:0], 32'h44);
        e = rsp_q[3];
        chk("rd_err3", 32'(e[32]), 0);
        step(); step();

        // Slave error after 3 waits, then a queued read proceeds
        clear_stats(); slave_wait = 3; slave_err = 1;
        push_cmd(1, 32'h30, 32'h1234_5678);
        push_cmd(0, 32'h8, 32'h0);
        wait_rsp(2);
        e = rsp_q[0];
        chk("slverr_error", 32'(e[32]), 1);
        chk("slverr_timeout", 32'(e[33]), 0);
        chk("slverr_rdata", e[31:0], 0);
        e = rsp_q[1];
        chk("slverr_next_data", e[31:0], 32'h22);
        chk("slverr_next_err", 32'(e[32]), 0);
        chk("slverr_access_cycles", 32'(acc_cnt), 8);
        slave_err = 0;
        step(); step();

        // Timeout: pready never asserted
        clear_stats(); slave_wait = -1;
        push_cmd(0, 32'h20, 32'h0);
        wait_rsp(1);
        e = rsp_q[0];
        chk("tmo_access_cycles", 32'(acc_cnt), 16);
        chk("tmo_error", 32'(e[32]), 1);
        chk("tmo_timeout", 32'(e[33]), 1);
        chk("tmo_rdata", e[31:0], 0);
        step();
        chk("tmo_idle", 32'(psel), 0);

        // Full FIFO: push offered during a pop is refused, accepted next edge
        clear_stats(); slave_wait = 5;
        push_cmd(0, 32'h4, 32'h0);
        push_cmd(0, 32'h8, 32'h0);
        push_cmd(0, 32'hC, 32'h0);
        push_cmd(0, 32'h10, 32'h0);
        push_cmd(0, 32'h14, 32'h0);
        chk("full_cmd_ready", 32'(cmd_ready), 0);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h18;
        for (int i = 0; i < 50 && rsp_q.size() == 0; i++) step();
        chk("full_pop_rsp", 32'(rsp_q.size()), 1);
        chk("full_refused_ready", 32'(cmd_ready), 1);
        step();
        chk("full_accepted_ready", 32'(cmd_ready), 0);
        cmd_valid = 0;
        wait_rsp(6);
        chk("full_data0", rsp_q[0][31:0], 32'h11);
        chk("full_data1", rsp_q[1][31:0], 32'h22);
        chk("full_data2", rsp_q[2][31:0], 32'h33);
        chk("full_data3", rsp_q[3][31:0], 32'h44);
        chk("full_data4", rsp_q[4][31:0], 32'h55);
        chk("full_data5", rsp_q[5][31:0], 32'h66);
        step(); step();

        // Asynchronous reset during ACCESS with two commands queued
        clear_stats(); slave_wait = -1;
        push_cmd(1, 32'h40, 32'hDEAD_BEEF);
        push_cmd(1, 32'h44, 32'h1);
        push_cmd(1, 32'h48, 32'h2);
        for (int i = 0; i < 20 && !penable; i++) step();
        chk("mid_in_access", 32'(penable), 1);
        rstn = 0;
        #2;
        chk("mid_rst_psel", 32'(psel), 0);
        chk("mid_rst_penable", 32'(penable), 0);
        chk("mid_rst_pwrite", 32'(pwrite), 0);
        chk("mid_rst_paddr", paddr, 0);
        chk("mid_rst_pwdata", pwdata, 0);
        chk("mid_rst_pstrb", 32'(pstrb), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        clear_stats();
        step(); step();
        rstn = 1;
        for (int i = 0; i < 30; i++) step();
        chk("mid_no_rsp", 32'(rsp_q.size()), 0);
        chk("mid_no_psel", 32'(psel_cnt), 0);
        chk("mid_busy_after", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
